// File: rtl/keypad_pkg.sv
//------------------------------------------------------------------------------
// Module      : keypad_pkg
// Description : Shared types, defaults and pass classifier for keypad_scanner.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package keypad_pkg;

    localparam int unsigned c_scan_div_default       = 1000;
    localparam int unsigned c_debounce_scans_default = 4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PRESS_DB = 2'd1,
        ST_HELD     = 2'd2,
        ST_REL_DB   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        PASS_NONE   = 2'd0,
        PASS_SINGLE = 2'd1,
        PASS_MULTI  = 2'd2
    } pass_kind_t;

    typedef struct packed {
        pass_kind_t kind;
        logic [3:0] key;
    } pass_result_t;

    // Key index in the map is row*4+col; key field is meaningful only for SINGLE.
    function automatic pass_result_t classify_pass(input logic [15:0] map);
        pass_result_t res;
        int unsigned  n;
        res.kind = PASS_NONE;
        res.key  = 4'd0;
        n        = 0;
        for (int i = 0; i < 16; i++) begin
            if (map[i]) begin
                n       = n + 1;
                res.key = 4'(i);
            end
        end
        if (n == 1)
            res.kind = PASS_SINGLE;
        else if (n > 1)
            res.kind = PASS_MULTI;
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/keypad_scanner_sync2.sv
//------------------------------------------------------------------------------
// Module      : sync2
// Description : Two-flop synchronizer, resets to all-ones (idle pulled-up rows).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sync2 #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= '1;
            r_sync <= '1;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule

`default_nettype wire

// File: rtl/keypad_scanner.sv
//------------------------------------------------------------------------------
// Module      : keypad_scanner
// Description : 4x4 matrix keypad column scanner with pass-level debouncing.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV       = c_scan_div_default,
    parameter int unsigned DEBOUNCE_SCANS = c_debounce_scans_default
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int unsigned DIV_W = $clog2(SCAN_DIV);
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DIV_W-1:0] c_div_last = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] c_deb      = CNT_W'(DEBOUNCE_SCANS);

    logic [3:0]       w_rows;
    logic [DIV_W-1:0] r_div;
    logic [1:0]       r_col;
    logic [15:0]      r_acc;
    logic [15:0]      r_pass_map;
    logic             r_pass_valid;
    logic [15:0]      w_col_hits;
    logic             w_dwell_end;

    sync2 #(.WIDTH(4)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (row_in),
        .q   (w_rows)
    );

    assign w_dwell_end = (r_div == c_div_last);
    assign col_out     = ~(4'b0001 << r_col);

    always_comb begin
        w_col_hits = 16'd0;
        for (int r = 0; r < 4; r++)
            w_col_hits[r*4 + int'(r_col)] = ~w_rows[r];
    end

    // Scan timer free-runs; a completed pass map is published for one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div        <= '0;
            r_col        <= 2'd0;
            r_acc        <= 16'd0;
            r_pass_map   <= 16'd0;
            r_pass_valid <= 1'b0;
        end else begin
            r_pass_valid <= 1'b0;
            if (w_dwell_end) begin
                r_div <= '0;
                r_col <= r_col + 2'd1;
                if (r_col == 2'd3) begin
                    r_pass_map   <= r_acc | w_col_hits;
                    r_acc        <= 16'd0;
                    r_pass_valid <= 1'b1;
                end else begin
                    r_acc <= r_acc | w_col_hits;
                end
            end else begin
                r_div <= r_div + 1'b1;
            end
        end
    end

    state_t           r_state, w_state_nxt;
    logic [3:0]       r_cand, w_cand_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
    logic [3:0]       r_key_code;
    logic             r_key_valid;
    logic             w_accept;
    pass_result_t     w_res;
    logic             w_single;
    logic             w_match;

    assign w_res     = classify_pass(r_pass_map);
    assign w_single  = (w_res.kind == PASS_SINGLE);
    assign w_match   = w_single && (w_res.key == r_cand);
    assign w_cnt_inc = r_cnt + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_cand_nxt  = r_cand;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        if (r_pass_valid) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_single) begin
                        w_cand_nxt = w_res.key;
                        if (DEBOUNCE_SCANS == 1) begin
                            w_state_nxt = ST_HELD;
                            w_cnt_nxt   = '0;
                            w_accept    = 1'b1;
                        end else begin
                            w_state_nxt = ST_PRESS_DB;
                            w_cnt_nxt   = CNT_W'(1);
                        end
                    end
                end
                ST_PRESS_DB: begin
                    if (w_match) begin
                        if (w_cnt_inc == c_deb) begin
                            w_state_nxt = ST_HELD;
                            w_cnt_nxt   = '0;
                            w_accept    = 1'b1;
                        end else begin
                            w_cnt_nxt = w_cnt_inc;
                        end
                    end else if (w_single) begin
                        w_cand_nxt = w_res.key;
                        w_cnt_nxt  = CNT_W'(1);
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = '0;
                    end
                end
                ST_HELD: begin
                    if (!w_match) begin
                        // A single release pass already satisfies a 1-pass debounce.
                        if (DEBOUNCE_SCANS == 1 && !w_single) begin
                            w_state_nxt = ST_IDLE;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_state_nxt = ST_REL_DB;
                            w_cnt_nxt   = CNT_W'(1);
                        end
                    end
                end
                ST_REL_DB: begin
                    if (w_match) begin
                        w_state_nxt = ST_HELD;
                        w_cnt_nxt   = '0;
                    end else if (w_single) begin
                        w_cnt_nxt = '0;
                    end else if (w_cnt_inc >= c_deb) begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cand      <= 4'd0;
            r_cnt       <= '0;
            r_key_code  <= 4'd0;
            r_key_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cand      <= w_cand_nxt;
            r_cnt       <= w_cnt_nxt;
            r_key_valid <= w_accept;
            if (w_accept)
                r_key_code <= w_cand_nxt;
        end
    end

    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;
    assign key_held  = (r_state == ST_HELD) || (r_state == ST_REL_DB);

endmodule

`default_nettype wire

// File: tb/tb_keypad_scanner.sv
//------------------------------------------------------------------------------
// Module      : tb_keypad_scanner
// Description : Scoreboard bench for keypad_scanner with a 4x4 key matrix model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_keypad_scanner;

    localparam int unsigned SCAN_DIV       = 4;
    localparam int unsigned DEBOUNCE_SCANS = 3;
    localparam int unsigned PASS_CYC       = 4 * SCAN_DIV;

    logic        clk;
    logic        rst;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;

    logic [15:0] keys;
    int          n_checks;
    int          n_errors;
    int          n_pulses;
    int          exp_pulses;
    int          exp_q[$];
    logic        prev_valid;

    keypad_scanner #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .row_in    (row_in),
        .col_out   (col_out),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pressed key (r,c) pulls row r low while column c is driven low.
    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4 + c] && !col_out[c])
                    row_in[r] = 1'b0;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && key_valid) begin
            n_pulses++;
            check("valid_width", {31'd0, prev_valid}, 32'd0);
            check("held_at_valid", {31'd0, key_held}, 32'd1);
            if (exp_q.size() > 0) begin
                int e;
                e = exp_q.pop_front();
                check("key_code", {28'd0, key_code}, e);
            end
        end
        prev_valid = key_valid;
    end

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic run_pass(input logic [15:0] m, input int n);
        for (int i = 0; i < n; i++) begin
            keys = m;
            repeat (PASS_CYC) @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_key(input int code);
        exp_q.push_back(code);
        exp_pulses++;
    endtask

    task automatic end_scenario(input string tag);
        check({tag, "_pulses"}, n_pulses, exp_pulses);
        check({tag, "_pending"}, exp_q.size(), 0);
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        n_pulses   = 0;
        exp_pulses = 0;
        prev_valid = 1'b0;
        keys       = 16'd0;
        rst        = 1'b1;

        // Reset state and column rotation
        do_reset();
        check("rst_valid", {31'd0, key_valid}, 0);
        check("rst_held", {31'd0, key_held}, 0);
        check("rst_code", {28'd0, key_code}, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("col0_dwell", {28'd0, col_out}, 32'hE);
        end
        @(negedge clk);
        check("col1_start", {28'd0, col_out}, 32'hD);
        for (int i = 0; i < 4; i++) @(negedge clk);
        check("col2_start", {28'd0, col_out}, 32'hB);

        // Steady key (1,2) accepted once, then released
        do_reset();
        run_pass(16'h0040, 3);
        expect_key(6);
        run_pass(16'h0040, 1);
        check("s1_held", {31'd0, key_held}, 1);
        check("s1_code", {28'd0, key_code}, 6);
        run_pass(16'h0000, 4);
        check("s1_released", {31'd0, key_held}, 0);
        check("s1_code_kept", {28'd0, key_code}, 6);
        end_scenario("s1");

        // Candidate change in press debounce, foreign key during release
        do_reset();
        run_pass(16'h0040, 2);
        run_pass(16'h0020, 3);
        expect_key(5);
        run_pass(16'h0020, 1);
        check("s2_code", {28'd0, key_code}, 5);
        run_pass(16'h0200, 2);
        run_pass(16'h0000, 2);
        check("s2_still_held", {31'd0, key_held}, 1);
        run_pass(16'h0000, 2);
        check("s2_released", {31'd0, key_held}, 0);
        end_scenario("s2");

        // Interrupted press never accepted
        do_reset();
        run_pass(16'h0040, 2);
        run_pass(16'h0000, 1);
        run_pass(16'h0040, 2);
        run_pass(16'h0000, 1);
        check("s3_held", {31'd0, key_held}, 0);
        end_scenario("s3");

        // Two keys together are ignored
        do_reset();
        run_pass(16'h0003, 5);
        run_pass(16'h0000, 1);
        check("s4_held", {31'd0, key_held}, 0);
        end_scenario("s4");

        // Release bounce: no second pulse, held falls after 3rd empty pass
        do_reset();
        run_pass(16'h0040, 3);
        expect_key(6);
        run_pass(16'h0040, 1);
        run_pass(16'h0000, 1);
        run_pass(16'h0040, 1);
        run_pass(16'h0000, 2);
        check("s5_held_mid", {31'd0, key_held}, 1);
        run_pass(16'h0000, 1);
        @(negedge clk);
        check("s5_held_last", {31'd0, key_held}, 1);
        @(negedge clk);
        check("s5_held_fall", {31'd0, key_held}, 0);
        end_scenario("s5");

        // Reset while HELD; key stays down and is re-accepted after 3 passes
        do_reset();
        run_pass(16'h0040, 3);
        expect_key(6);
        run_pass(16'h0040, 1);
        check("s6_held_pre", {31'd0, key_held}, 1);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        check("s6_rst_held", {31'd0, key_held}, 0);
        check("s6_rst_code", {28'd0, key_code}, 0);
        check("s6_rst_valid", {31'd0, key_valid}, 0);
        check("s6_rst_col", {28'd0, col_out}, 32'hE);
        rst = 1'b0;
        run_pass(16'h0040, 3);
        check("s6_no_early", n_pulses, exp_pulses);
        expect_key(6);
        run_pass(16'h0040, 1);
        check("s6_held_post", {31'd0, key_held}, 1);
        check("s6_code_post", {28'd0, key_code}, 6);
        end_scenario("s6");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
